cp_phase_ctrl: RTL and testbench
================================

// Module: cp_phase_ctrl
// PURPOSE
//  Sequencer for the on-chip charge pump. Generates two registered, non-overlapping pump phases
//  (ph1/ph2) from clk, with a soft-start frequency ramp, pulse-skip regulation from the analog
//  output comparator, and a no-regulation timeout fault. Sits between the digital I/O and the pump switch drivers.
// PARAMETERS
//  DIV_W          4   width of cfg_div (phase half-length in clk cycles)
//  DEAD_CYCLES    1   clk cycles with both phases low between ph1 and ph2 (>=1)
//  SS_STEPS       3   soft-start extra half-length at first pump cycle; drops by 1 per pump cycle
//  TIMEOUT_CYCLES 8   consecutive pump cycles with comp_low=1 before FAULT (>=1)
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  en        in   1      pump enable (level)
//  cfg_div   in   DIV_W  base phase half-length; 0 is treated as 1
//  comp_low  in   1      comparator: 1 = pump output below target (asynchronous to clk)
//  ph1       out  1      pump phase 1 drive
//  ph2       out  1      pump phase 2 drive
//  active    out  1      1 in SOFTSTART or REGULATE
//  fault     out  1      1 in FAULT
//  state     out  2      IDLE=0 SOFTSTART=1 REGULATE=2 FAULT=3
// BEHAVIOUR
//  - Reset: state=IDLE, ph1=ph2=0, active=0, fault=0, all counters 0. All outputs registered.
//  - Main FSM: IDLE -(en)-> SOFTSTART, loading ss_cnt=SS_STEPS. If SS_STEPS=0, go straight to REGULATE.
//    SOFTSTART -(ss_cnt=0 at pump-cycle end)-> REGULATE.
//    REGULATE -(timeout count reaches TIMEOUT_CYCLES)-> FAULT.
//    FAULT stays until en=0, then -> IDLE. en=1 while in FAULT does not restart the pump.
//  - en=0 in any state: next edge state=IDLE, ph1=ph2=0, phase FSM reset (abort mid-segment).
//  - Phase FSM per pump cycle: P1 (ph1=1, half_len cycles), D1 (both 0, DEAD_CYCLES),
//    P2 (ph2=1, half_len), D2 (both 0, DEAD_CYCLES). ph1 and ph2 never both 1 in any cycle.
//  - half_len = max(cfg_div,1) + ss_cnt, computed at DIV_W+1 bits with no wrap.
//    cfg_div and ss_cnt are sampled only on entry to P1; mid-cycle cfg_div changes take effect next cycle.
//  - Start latency: on the edge that samples en=1 in IDLE, state<=SOFTSTART; on the next edge ph1<=1.
//  - SOFTSTART: ss_cnt decrements at the end of each D2. No pulse skipping. Timeout counter held at 0.
//  - REGULATE, at each pump-cycle boundary (end of D2, or each clk while waiting):
//    comp_s=1: enter P1 and increment tcnt. On the increment that makes tcnt=TIMEOUT_CYCLES,
//      go to FAULT instead (ph1 stays 0).
//    comp_s=0: skip. Both phases stay low, tcnt clears to 0, re-check every clk.
//  - comp_s is the registered comparator (see CONFIGURATION). It is sampled only at boundaries.
//  - FAULT: ph1=ph2=0, fault=1, tcnt and ss_cnt frozen. Leaving FAULT via IDLE clears them.
// CONFIGURATION
//  CP_COMP_SYNC_EN defined: comp_low goes through a 2-flop synchronizer, so comp_s lags 2 clk.
//  CP_COMP_SYNC_EN undefined: single capture flop, so comp_s lags 1 clk.
//  FSM behaviour is otherwise identical. Bench must account for the 1- vs 2-cycle lag.
// TESTING  (DIV_W=4, DEAD_CYCLES=1, SS_STEPS=3, TIMEOUT_CYCLES=8)
//  1 rst=1 mid-run with ph1=1 -> same cycle (async) ph1=ph2=0, state=0, fault=0; holds while rst=1.
//  2 cfg_div=2, comp_low=1, en 0->1 -> ph1 high 2nd edge later. P1 lengths 5,4,3 in SOFTSTART,
//    then state=2 with P1/P2 = 2 cycles and D1/D2 = 1 cycle. Never ph1&ph2.
//  3 REGULATE, comp_low=0 -> both phases low after the current cycle ends. tcnt=0.
//    comp_low=1 again -> P1 starts within sync lag + 1 clk.
//  4 REGULATE, comp_low held 1 -> after 7 full pump cycles, state=3, fault=1, phases 0.
//    en still 1 -> stays 3. en=0 -> state=0. en=1 -> SOFTSTART again.
//  5 cfg_div=0 -> treated as 1 (REGULATE P1 = 1 cycle).
//    cfg_div 2->6 written mid-P2 -> current cycle unchanged, next P1 = 6.
//  6 en dropped mid-P1 in SOFTSTART -> next edge ph1=0, state=0.
//    Re-enable -> ss_cnt reloads to 3 (first P1 = cfg_div+3).

Source files
------------

// File: rtl/cp_phase_ctrl.sv
// -----------------------------------------------------------------------------
// cp_phase_ctrl
// -----------------------------------------------------------------------------
// Sequencer for the on-chip charge pump. It drives the two pump switch phases
// (ph1/ph2) as registered, non-overlapping pulses. It also provides:
//   * a soft-start ramp: the phase half-length starts at cfg_div + SS_STEPS
//     and shrinks by one each pump cycle until it reaches the base length;
//   * pulse-skip regulation: once the pump is regulating, a new pump cycle
//     starts only while the output comparator reports the output below target;
//   * a timeout fault: if the comparator stays low for TIMEOUT_CYCLES
//     consecutive pump cycles, the pump stops and raises fault.
//
// Parameters
//   DIV_W          width of cfg_div
//   DEAD_CYCLES    clk cycles with both phases low between ph1 and ph2 (>= 1)
//   SS_STEPS       extra half-length of the first soft-start pump cycle
//   TIMEOUT_CYCLES consecutive comparator-low pump cycles before FAULT (>= 1)
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous reset, active-high
//   en        in   pump enable (level); low aborts everything back to IDLE
//   cfg_div   in   base phase half-length in clk cycles (0 behaves as 1)
//   comp_low  in   comparator, 1 = pump output below target (async to clk)
//   ph1       out  pump phase 1 drive (registered)
//   ph2       out  pump phase 2 drive (registered)
//   active    out  1 while in SOFTSTART or REGULATE (registered)
//   fault     out  1 while in FAULT (registered)
//   state     out  IDLE=0 SOFTSTART=1 REGULATE=2 FAULT=3
//
// Build option
//   CP_COMP_SYNC_EN  defined: comp_low passes through a 2-flop synchronizer
//                    (2 clk lag). Undefined: a single capture flop (1 clk lag).
// -----------------------------------------------------------------------------
module cp_phase_ctrl #(
    parameter int DIV_W          = 4,
    parameter int DEAD_CYCLES    = 1,
    parameter int SS_STEPS       = 3,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             comp_low,
    output logic             ph1,
    output logic             ph2,
    output logic             active,
    output logic             fault,
    output logic [1:0]       state
);

    // Half-length is one bit wider than cfg_div so max(cfg_div,1)+ss_cnt
    // cannot wrap.
    localparam int HL_W  = DIV_W + 1;
    localparam int DC_W  = $clog2(DEAD_CYCLES + 1);
    localparam int CNT_W = (HL_W > DC_W) ? HL_W : DC_W;
    localparam int SS_W  = (SS_STEPS < 1) ? 1 : $clog2(SS_STEPS + 1);
    localparam int TC_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SOFTSTART = 2'd1,
        S_REGULATE  = 2'd2,
        S_FAULT     = 2'd3
    } main_t;

    // PH_WAIT is the pump-cycle boundary: both phases low, waiting for the
    // decision to start the next P1.
    typedef enum logic [2:0] {
        PH_WAIT = 3'd0,
        PH_P1   = 3'd1,
        PH_D1   = 3'd2,
        PH_P2   = 3'd3,
        PH_D2   = 3'd4
    } phase_t;

    // -------------------------------------------------------------------------
    // Comparator capture
    // -------------------------------------------------------------------------
    logic comp_s;

`ifdef CP_COMP_SYNC_EN
    logic comp_meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_meta <= 1'b0;
            comp_s    <= 1'b0;
        end else begin
            comp_meta <= comp_low;
            comp_s    <= comp_meta;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_s <= 1'b0;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every flop samples values from before the edge.
            comp_s <= comp_low;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    main_t            main_q,  main_d;
    phase_t           phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;    // cycles left in current segment - 1
    logic [HL_W-1:0]  hl_q,    hl_d;     // half-length latched at P1 entry
    logic [SS_W-1:0]  ss_q,    ss_d;     // soft-start extra half-length
    logic [TC_W-1:0]  tcnt_q,  tcnt_d;   // consecutive comparator-low cycles

    logic ph1_d, ph2_d, active_d, fault_d;

    // Combinational helpers
    logic             seg_done;
    logic             boundary;
    logic             regulate_now;
    logic [SS_W-1:0]  ss_eff;
    logic [DIV_W-1:0] div_eff;
    logic [HL_W-1:0]  hl_new;

    // -------------------------------------------------------------------------
    // Process 1: state register (outputs are registered here as well)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q  <= S_IDLE;
            phase_q <= PH_WAIT;
            cnt_q   <= '0;
            hl_q    <= '0;
            ss_q    <= '0;
            tcnt_q  <= '0;
            ph1     <= 1'b0;
            ph2     <= 1'b0;
            active  <= 1'b0;
            fault   <= 1'b0;
        end else begin
            main_q  <= main_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            hl_q    <= hl_d;
            ss_q    <= ss_d;
            tcnt_q  <= tcnt_d;
            ph1     <= ph1_d;
            ph2     <= ph2_d;
            active  <= active_d;
            fault   <= fault_d;
        end
    end

    assign state = main_q;

    // -------------------------------------------------------------------------
    // Process 2: next-state logic (main FSM and phase FSM)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        main_d       = main_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        hl_d         = hl_q;
        ss_d         = ss_q;
        tcnt_d       = tcnt_q;
        seg_done     = (cnt_q == '0);
        boundary     = 1'b0;
        regulate_now = 1'b0;
        ss_eff       = ss_q;
        div_eff      = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        hl_new       = '0;

        if (!en) begin
            // Enable low aborts whatever is in progress, mid-segment included.
            main_d  = S_IDLE;
            phase_d = PH_WAIT;
            cnt_d   = '0;
            hl_d    = '0;
            ss_d    = '0;
            tcnt_d  = '0;
        end else begin
            case (main_q)
                S_IDLE: begin
                    ss_d    = SS_W'(SS_STEPS);
                    tcnt_d  = '0;
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                    main_d  = (SS_STEPS == 0) ? S_REGULATE : S_SOFTSTART;
                end

                S_SOFTSTART, S_REGULATE: begin
                    // Segment sequencing inside a pump cycle.
                    case (phase_q)
                        PH_P1: begin
                            if (seg_done) begin
                                phase_d = PH_D1;
                                cnt_d   = CNT_W'(DEAD_CYCLES - 1);
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                        PH_D1: begin
                            if (seg_done) begin
                                phase_d = PH_P2;
                                cnt_d   = CNT_W'(hl_q) - CNT_W'(1);
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                        PH_P2: begin
                            if (seg_done) begin
                                phase_d = PH_D2;
                                cnt_d   = CNT_W'(DEAD_CYCLES - 1);
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                        PH_D2: begin
                            if (seg_done) begin
                                boundary = 1'b1;
                            end else begin
                                cnt_d = cnt_q - CNT_W'(1);
                            end
                        end
                        default: boundary = 1'b1;   // PH_WAIT
                    endcase

                    // Pump-cycle boundary: decide whether the next P1 starts.
                    if (boundary) begin
                        regulate_now = (main_q == S_REGULATE);

                        // Soft-start steps down at the end of each full cycle;
                        // the step that reaches zero hands this very boundary
                        // over to regulation so pumping continues seamlessly.
                        if (main_q == S_SOFTSTART && phase_q == PH_D2) begin
                            ss_eff = (ss_q == '0) ? '0 : ss_q - SS_W'(1);
                            ss_d   = ss_eff;
                            if (ss_eff == '0) begin
                                main_d       = S_REGULATE;
                                regulate_now = 1'b1;
                            end
                        end

                        hl_new = HL_W'(div_eff) + HL_W'(ss_eff);

                        if (!regulate_now) begin
                            phase_d = PH_P1;
                            hl_d    = hl_new;
                            cnt_d   = CNT_W'(hl_new) - CNT_W'(1);
                            tcnt_d  = '0;
                        end else if (comp_s) begin
                            if (tcnt_q == TC_W'(TIMEOUT_CYCLES - 1)) begin
                                // Pump has not reached target for too long.
                                main_d  = S_FAULT;
                                phase_d = PH_WAIT;
                                cnt_d   = '0;
                                tcnt_d  = TC_W'(TIMEOUT_CYCLES);
                            end else begin
                                phase_d = PH_P1;
                                hl_d    = hl_new;
                                cnt_d   = CNT_W'(hl_new) - CNT_W'(1);
                                tcnt_d  = tcnt_q + TC_W'(1);
                            end
                        end else begin
                            // Output at target: skip, re-check next clk.
                            phase_d = PH_WAIT;
                            cnt_d   = '0;
                            tcnt_d  = '0;
                        end
                    end
                end

                S_FAULT: begin
                    // Only en=0 leaves FAULT; counters stay frozen here.
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end

                default: begin
                    main_d  = S_IDLE;
                    phase_d = PH_WAIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Process 3: output decode from next state, registered in process 1
    // -------------------------------------------------------------------------
    always_comb begin
        ph1_d    = (phase_d == PH_P1);
        ph2_d    = (phase_d == PH_P2);
        active_d = (main_d == S_SOFTSTART) || (main_d == S_REGULATE);
        fault_d  = (main_d == S_FAULT);
    end

endmodule

// File: tb/tb_cp_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cp_phase_ctrl
// Directed self-checking bench for cp_phase_ctrl with DIV_W=4, DEAD_CYCLES=1,
// SS_STEPS=3, TIMEOUT_CYCLES=8. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_cp_phase_ctrl;

`ifdef CP_COMP_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 1;
`endif
    localparam int BOUND = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] cfg_div;
    logic       comp_low;
    logic       ph1, ph2, active, fault;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;
    bit ovl_seen = 1'b0;

    always #5 clk = ~clk;

    cp_phase_ctrl #(
        .DIV_W(4),
        .DEAD_CYCLES(1),
        .SS_STEPS(3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_div(cfg_div),
        .comp_low(comp_low),
        .ph1(ph1),
        .ph2(ph2),
        .active(active),
        .fault(fault),
        .state(state)
    );

    // Phase overlap monitor.
    always @(negedge clk) if (ph1 === 1'b1 && ph2 === 1'b1) ovl_seen = 1'b1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Count falling edges while the selected condition holds:
    // 1 = ph1 high, 2 = ph2 high, 0 = both low.
    task automatic run_len(input int sel, output int len);
        len = 0;
        while (len < BOUND &&
               ((sel == 1 && ph1 === 1'b1) ||
                (sel == 2 && ph2 === 1'b1) ||
                (sel == 0 && ph1 === 1'b0 && ph2 === 1'b0))) begin
            len++;
            @(negedge clk);
        end
    endtask

    // Falling edges until ph1 is seen high.
    task automatic wait_ph1(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph1 !== 1'b1 && n < BOUND);
    endtask

    // Measure one full pump cycle starting at the first ph1-high sample.
    task automatic cyc(input string tag, input int est,
                       input int e1, input int e2, input int e3, input int e4);
        int a, b, c, d;
        check({tag, "_state"}, 32'(state), 32'(est));
        run_len(1, a);
        run_len(0, b);
        run_len(2, c);
        run_len(0, d);
        check(tag, {8'(a), 8'(b), 8'(c), 8'(d)}, {8'(e1), 8'(e2), 8'(e3), 8'(e4)});
    endtask

    initial begin
        int a, b, c, d, n;

        rst      = 1'b1;
        en       = 1'b0;
        cfg_div  = 4'd2;
        comp_low = 1'b1;

        // Reset state
        step(2);
        check("rst_state",  32'(state),  32'd0);
        check("rst_ph1",    32'(ph1),    32'd0);
        check("rst_ph2",    32'(ph2),    32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_fault",  32'(fault),  32'd0);
        rst = 1'b0;
        step(3);

        // Start latency and soft-start ramp 5,4,3 then regulation at 2
        en = 1'b1;
        step(1);
        check("start_state",  32'(state),  32'd1);
        check("start_ph1_lo", 32'(ph1),    32'd0);
        check("start_active", 32'(active), 32'd1);
        step(1);
        check("start_ph1_hi", 32'(ph1),    32'd1);
        cyc("ss1",  1, 5, 1, 5, 1);
        cyc("ss2",  1, 4, 1, 4, 1);
        cyc("ss3",  1, 3, 1, 3, 1);
        cyc("reg1", 2, 2, 1, 2, 1);

        // Pulse skip: current cycle completes, then phases stay low
        comp_low = 1'b0;
        run_len(1, a);
        run_len(0, b);
        run_len(2, c);
        check("skip_last_cycle", {8'(a), 8'(b), 8'(c)}, {8'd2, 8'd1, 8'd2});
        step(8);
        check("skip_ph1",   32'(ph1),   32'd0);
        check("skip_ph2",   32'(ph2),   32'd0);
        check("skip_state", 32'(state), 32'd2);
        comp_low = 1'b1;
        wait_ph1(n);
        check("resume_latency", 32'(n), 32'(LAG + 1));

        // Timeout: counter restarted by the skip, 7 full cycles then FAULT
        for (int i = 1; i <= 6; i++) cyc("to_cycle", 2, 2, 1, 2, 1);
        run_len(1, a);
        run_len(0, b);
        run_len(2, c);
        check("to_cycle7", {8'(a), 8'(b), 8'(c)}, {8'd2, 8'd1, 8'd2});
        check("to_pre_state", 32'(state), 32'd2);
        step(1);
        check("fault_state",  32'(state),  32'd3);
        check("fault_flag",   32'(fault),  32'd1);
        check("fault_active", 32'(active), 32'd0);
        check("fault_ph",     32'({ph1, ph2}), 32'd0);
        step(5);
        check("fault_hold_state", 32'(state), 32'd3);
        check("fault_hold_ph1",   32'(ph1),   32'd0);
        en = 1'b0;
        step(1);
        check("fault_exit_state", 32'(state), 32'd0);
        check("fault_exit_flag",  32'(fault), 32'd0);
        en = 1'b1;
        step(1);
        check("restart_state", 32'(state), 32'd1);
        step(1);
        check("restart_ph1", 32'(ph1), 32'd1);
        cyc("restart_ss1", 1, 5, 1, 5, 1);

        // Abort mid-P1 of the second soft-start cycle, then reload
        step(2);
        check("abort_mid_p1", 32'(ph1), 32'd1);
        en = 1'b0;
        step(1);
        check("abort_ph1",   32'(ph1),   32'd0);
        check("abort_state", 32'(state), 32'd0);
        en = 1'b1;
        wait_ph1(n);
        check("reen_latency", 32'(n), 32'd2);
        cyc("reload_ss1", 1, 5, 1, 5, 1);

        // cfg_div=0 behaves as 1
        en = 1'b0;
        cfg_div = 4'd0;
        step(2);
        en = 1'b1;
        wait_ph1(n);
        check("div0_latency", 32'(n), 32'd2);
        cyc("div0_ss1", 1, 4, 1, 4, 1);
        cyc("div0_ss2", 1, 3, 1, 3, 1);
        cyc("div0_ss3", 1, 2, 1, 2, 1);
        cyc("div0_reg", 2, 1, 1, 1, 1);

        // cfg_div written mid-cycle applies from the next P1
        cfg_div = 4'd2;
        cyc("div_chg_cur",  2, 1, 1, 1, 1);
        cyc("div_chg_next", 2, 2, 1, 2, 1);
        run_len(1, a);
        run_len(0, b);
        check("div6_first_half", {8'(a), 8'(b)}, {8'd2, 8'd1});
        cfg_div = 4'd6;
        run_len(2, c);
        run_len(0, d);
        check("div6_mid_p2", {8'(c), 8'(d)}, {8'd2, 8'd1});
        cyc("div6_next", 2, 6, 1, 6, 1);

        // Asynchronous reset while ph1 is high
        check("pre_rst_ph1", 32'(ph1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_ph",    32'({ph1, ph2}), 32'd0);
        check("async_rst_state", 32'(state),      32'd0);
        check("async_rst_fault", 32'(fault),      32'd0);
        step(2);
        check("rst_hold_ph1",   32'(ph1),   32'd0);
        check("rst_hold_state", 32'(state), 32'd0);
        rst = 1'b0;
        en  = 1'b0;
        step(1);

        check("no_overlap", 32'(ovl_seen), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
